// File: rtl/dark_debug_pkg.sv
// dark_debug_pkg: shared types/constants for the debug frame transmitter.
// Holds the FSM state encoding, the default SYNC header and frame geometry.
package dark_debug_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_HDR  = S_HDR;
  localparam logic [1:0] ST_DATA = S_DATA;
  localparam logic [1:0] ST_CHK  = S_CHK;

  localparam logic [7:0] SYNC_DEF   = 8'hA5;
  localparam int         DATA_BYTES = 16;
  localparam logic [3:0] LAST_IDX   = 4'(DATA_BYTES - 1);

endpackage

// File: rtl/dark_debug_if.sv
// dark_debug_if: byte stream with valid/ready handshake.
// master drives TX_DATA/TX_VALID, slave drives TX_READY.
interface dark_debug_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY
  );
endinterface

// File: rtl/dark_debug_tx.sv
// dark_debug_tx: snapshots a 4x32 debug bundle and streams it as a
// byte frame: SYNC header, 16 data bytes (word 0 first, LSB first).
// Ports: XCLK clock, XRES async active-high reset, DEBUG bundle,
//   TRIG capture request, tx (master: TX_DATA/TX_VALID/TX_READY),
//   BUSY frame in progress, DROPS saturating lost-capture count.
// Macro DARK_DEBUG_CHKSUM_EN appends a mod-256 sum of the data bytes.
module dark_debug_tx
  import dark_debug_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEF,
  parameter bit         AUTO = 1'b0
) (
  input  logic             XCLK,
  input  logic             XRES,
  input  logic [3:0][31:0] DEBUG,
  input  logic             TRIG,
  dark_debug_if.master     tx,
  output logic             BUSY,
  output logic [7:0]       DROPS
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0][31:0] snap_q;
  logic [3:0][31:0] prev_q;
  logic [7:0]       drops_q;
  logic [7:0]       byte_sel;
  logic [7:0]       data_d;
  logic             evt, xfer, idle;

`ifdef DARK_DEBUG_CHKSUM_EN
  logic [7:0] sum_q;
`endif

  assign idle = (state_q == ST_IDLE);
  assign evt  = AUTO ? (DEBUG != prev_q) : TRIG;
  assign xfer = tx.TX_VALID & tx.TX_READY;

  assign byte_sel =
    snap_q[idx_q[3:2]][{idx_q[1:0], 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: if (evt) state_d = ST_HDR;
      ST_HDR: if (xfer) begin
        state_d = ST_DATA;
        idx_d   = '0;
      end
      ST_DATA: if (xfer) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
`ifdef DARK_DEBUG_CHKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef DARK_DEBUG_CHKSUM_EN
      ST_CHK: if (xfer) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = '0;
    unique case (state_q)
      ST_HDR:  data_d = SYNC;
      ST_DATA: data_d = byte_sel;
`ifdef DARK_DEBUG_CHKSUM_EN
      ST_CHK:  data_d = sum_q;
`endif
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      prev_q  <= '0;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev_q  <= DEBUG;
      if (evt && idle)
        snap_q <= DEBUG;
      if (evt && !idle && drops_q != 8'hFF)
        drops_q <= drops_q + 8'd1;
    end
  end

`ifdef DARK_DEBUG_CHKSUM_EN
  // Running sum of data bytes as they leave; cleared at capture.
  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES)
      sum_q <= '0;
    else if (evt && idle)
      sum_q <= '0;
    else if (xfer && state_q == ST_DATA)
      sum_q <= sum_q + byte_sel;
  end
`endif

  assign tx.TX_DATA  = data_d;
  assign tx.TX_VALID = !idle;
  assign BUSY        = !idle;
  assign DROPS       = drops_q;

endmodule

// File: doc/dark_debug_tx.md
DARK_DEBUG_TX -- requirements
Module: dark_debug_tx

Interface
REQ-001 Parameter SYNC, default 8'hA5: frame header byte.
REQ-002 Parameter AUTO, default 0: 1 = capture on any DEBUG change, 0 = capture on TRIG only.
REQ-003 XCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 XRES  input  1  reset, asynchronous, active-high.
REQ-005 DEBUG  input  [3:0][31:0]  debug bundle from darkdatapath; word 0 first.
REQ-006 TRIG  input  1  single-cycle capture request; ignored when AUTO=1.
REQ-007 TX_DATA  output  8  current frame byte.
REQ-008 TX_VALID  output  1  TX_DATA holds a valid byte.
REQ-009 TX_READY  input  1  sink accepts TX_DATA this cycle.
REQ-010 BUSY  output  1  a frame is in progress.
REQ-011 DROPS  output  8  saturating count of captures lost while BUSY.

Function
REQ-012 States IDLE, HDR, DATA, CHK; a byte transfers only in a cycle with TX_VALID=1 and TX_READY=1.
REQ-013 A capture event is TRIG=1 (AUTO=0), or DEBUG differing from its value in the previous cycle (AUTO=1).
REQ-014 In IDLE, a capture event:
- snapshots all 128 DEBUG bits into an internal register;
- moves the block to HDR.
REQ-015 Latency: the capture event is at cycle n; TX_VALID=1 with TX_DATA=SYNC from cycle n+1.
REQ-016 HDR: on transfer, go to DATA with byte index 0.
REQ-017 DATA:
- byte index k (0..15) emits snapshot word k/4, byte k%4, least significant byte first;
- each transfer increments k;
- a transfer at k=15 ends DATA (next state under REQ-026).
REQ-018 While TX_VALID=1 and TX_READY=0, TX_DATA and state are held stable; TX_VALID never deasserts without a transfer.
REQ-019 BUSY=1 in HDR, DATA and CHK; BUSY=0 in IDLE.
REQ-020 A capture event while BUSY=1:
- does not alter the snapshot or the frame in progress;
- increments DROPS, which saturates at 8'hFF.
REQ-021 A capture event in the cycle the final byte transfers counts as a drop; the next frame starts only on an event occurring in IDLE.
REQ-022 Back-to-back frames: with TX_READY held 1, a frame occupies exactly 17 cycles (18 with CHK), header to last byte.
REQ-023 When AUTO=1, the previous-DEBUG register updates every cycle, including while BUSY.

Reset
REQ-024 XRES=1 asynchronously forces:
- state IDLE; TX_VALID=0, TX_DATA=0, BUSY=0, DROPS=0;
- snapshot, byte index and previous-DEBUG register to 0.
REQ-025 XRES asserted mid-frame aborts the frame; no partial frame resumes after release, and the first capture event after release starts a fresh frame from HDR.

Configuration
REQ-026 Macro DARK_DEBUG_CHKSUM_EN:
- defined: after byte 15, state CHK emits the sum modulo 256 of the 16 data bytes, then returns to IDLE;
- undefined: CHK is absent, and the transfer at k=15 returns to IDLE.

Structure
REQ-027 Shared package dark_debug_pkg holds the state enum, the SYNC default and the constant DATA_BYTES=16.
REQ-028 No sub-module: a single FSM plus snapshot register, with the byte mux inline.

Verification
REQ-029 Frame content: AUTO=0, DEBUG[0]=32'h04030201, other words 0, TRIG pulse, TX_READY=1 -> bytes A5,01,02,03,04, then twelve 00; with DARK_DEBUG_CHKSUM_EN, a final byte 0A.
REQ-030 Backpressure: TX_READY toggled 1,0,0,1 during DATA -> TX_DATA/TX_VALID stable while TX_READY=0, and no byte lost or duplicated.
REQ-031 Drops: TRIG pulsed 300 times while BUSY -> DROPS=FF and frame content unchanged.
REQ-032 Auto mode: AUTO=1, DEBUG changed once -> exactly one frame; static DEBUG -> no frame.
REQ-033 Reset mid-frame: XRES pulsed at byte 7 -> TX_VALID=0 immediately; next TRIG yields a full frame starting with A5.
